// File: rtl/product_accumulator.sv
// Sums a stream of unsigned products into one saturated result per packet (dot product).
// Latency: result is visible on out_* one cycle after the handshake that carries in_last.
// Backpressure: in_ready drops while a result is held; it is released the cycle after out_ready takes the result.
//
// Ports:
//   clk, rst_n                     rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_product   product stream from the multiplier
//   in_last                        marks the final product of a packet (qualified by in_valid)
//   out_valid/out_ready            result handshake toward the consumer
//   out_sum/out_count/out_ovf      saturated sum, saturated product count, sticky saturation flag
module product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic               ready_q, ready_nxt;
    logic               load_out;

    logic               hs;
    logic [ACC_W:0]     sum_wide;
    logic               carry;
    logic [ACC_W-1:0]   acc_sat;
    logic [CNT_W-1:0]   cnt_sat;

    // in_ready is a register so that it reads 0 throughout reset and only
    // rises on the first edge after release.
    assign in_ready  = ready_q;
    assign out_valid = (state == HOLD);
    assign hs        = in_valid & ready_q;

    // One extra bit catches the carry; a carry pins the accumulator at all
    // ones, and any further add from all ones carries again, so it stays there.
    assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign carry    = sum_wide[ACC_W];
    assign acc_sat  = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign cnt_sat  = (&cnt) ? cnt : cnt + {{(CNT_W - 1){1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        load_out  = 1'b0;
        case (state)
            ACCUM: begin
                if (hs) begin
                    if (in_last) begin
                        // Post-add values go to the output registers; the
                        // running state starts clean for the next packet.
                        load_out  = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        state_nxt = HOLD;
                    end else begin
                        acc_nxt = acc_sat;
                        cnt_nxt = cnt_sat;
                        ovf_nxt = ovf | carry;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
        // Ready only after a full cycle back in ACCUM: gives the one-cycle
        // bubble after a result is taken, and keeps ready low during the
        // cycle a packet closes.
        ready_nxt = (state == ACCUM) && (state_nxt == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            ready_q   <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf_nxt;
            ready_q <= ready_nxt;
            if (load_out) begin
                out_sum   <= acc_sat;
                out_count <= cnt_sat;
                out_ovf   <= ovf | carry;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 24-bit and a 17-bit accumulator share one input stream.
// Expected values are hand-computed constants; outputs are sampled 1ns after the rising edge.
// Every comparison goes through check(), which feeds the summary counters.
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_product;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [23:0] out_sum_a;
    logic [7:0]  out_count_a;

    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [16:0] out_sum_b;
    logic [7:0]  out_count_b;

    int n_cmp = 0;
    int n_err = 0;

    product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_sum    (out_sum_a),
        .out_count  (out_count_a),
        .out_ovf    (out_ovf_a)
    );

    product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) u_dut17 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_sum    (out_sum_b),
        .out_count  (out_count_b),
        .out_ovf    (out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one product for exactly one edge.
    // Returns 1ns after the accepting edge.
    task automatic send(input logic [15:0] p, input logic last);
        int budget;
        budget = 50;
        while (!in_ready_a && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            in_valid   = 1'b1;
            in_product = p;
            in_last    = last;
            @(posedge clk);
            #1;
            in_valid   = 1'b0;
            in_last    = 1'b0;
            in_product = 16'hDEAD;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = 16'd0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // 1: reset state
        #1;
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_sum", out_sum_a, 0);
        check("rst_out_count", out_count_a, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_clocked", in_ready_a, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", in_ready_a, 0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_edge", in_ready_a, 1);

        // 2: 150+150+150, consumer always ready
        send(16'd150, 1'b0);
        check("t2_no_early_valid", out_valid_a, 0);
        send(16'd150, 1'b0);
        send(16'd150, 1'b1);
        check("t2_valid", out_valid_a, 1);
        check("t2_sum", out_sum_a, 450);
        check("t2_count", out_count_a, 3);
        check("t2_ovf", out_ovf_a, 0);
        check("t2_in_ready_hold", in_ready_a, 0);
        @(posedge clk);
        #1;
        check("t2_valid_one_cycle", out_valid_a, 0);
        check("t2_sum_kept", out_sum_a, 450);
        check("t2_in_ready_bubble", in_ready_a, 0);
        @(posedge clk);
        #1;
        check("t2_in_ready_back", in_ready_a, 1);

        // 3: result held under backpressure, input ignored meanwhile
        out_ready = 1'b0;
        send(16'd42, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_product = 16'd999;
            in_last    = 1'b1;
            check("t3_valid_held", out_valid_a, 1);
            check("t3_in_ready_low", in_ready_a, 0);
            check("t3_sum_stable", out_sum_a, 42);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("t3_count", out_count_a, 1);
        @(posedge clk);
        #1;
        check("t3_valid_drop", out_valid_a, 0);
        check("t3_in_ready_still_low", in_ready_a, 0);
        @(posedge clk);
        #1;
        check("t3_in_ready_two_later", in_ready_a, 1);

        // 4: saturation on the 17-bit instance, wide instance does not saturate
        send(16'd65535, 1'b0);
        send(16'd65535, 1'b0);
        send(16'd65535, 1'b1);
        check("t4_sum17", out_sum_b, 131071);
        check("t4_ovf17", out_ovf_b, 1);
        check("t4_count17", out_count_b, 3);
        check("t4_sum24", out_sum_a, 196605);
        check("t4_ovf24", out_ovf_a, 0);
        send(16'd5, 1'b1);
        check("t4_next_sum17", out_sum_b, 5);
        check("t4_next_ovf17", out_ovf_b, 0);
        check("t4_next_count17", out_count_b, 1);

        // 5: reset mid-packet discards the partial sum
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", in_ready_a, 0);
        check("t5_rst_out_sum", out_sum_a, 0);
        #2;
        rst_n = 1'b1;
        send(16'd7, 1'b1);
        check("t5_sum", out_sum_a, 7);
        check("t5_count", out_count_a, 1);

        // 6: gaps in in_valid, with in_last asserted while invalid
        send(16'd10, 1'b0);
        in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t6_gap_no_valid", out_valid_a, 0);
        end
        in_last = 1'b0;
        send(16'd20, 1'b0);
        send(16'd30, 1'b1);
        check("t6_valid", out_valid_a, 1);
        check("t6_sum", out_sum_a, 60);
        check("t6_count", out_count_a, 3);

        // Counter saturation: 300 products of 1
        for (int i = 0; i < 299; i++) begin
            send(16'd1, 1'b0);
        end
        send(16'd1, 1'b1);
        check("cnt_sat_count", out_count_a, 255);
        check("cnt_sat_sum", out_sum_a, 300);
        check("cnt_sat_ovf", out_ovf_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
